// File: rtl/wimax_pkg.sv
// Shared constants and types for the WiMAX transmit interleaver path.
package wimax_pkg;

  localparam int NCBPS_QPSK12 = 192;
  localparam int INTLV_D      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO carrying a {last, bit} payload with valid/ready on both sides.
module skid_fifo2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_data,
  output logic [1:0] count
);

  logic [1:0] mem0_r;
  logic [1:0] mem1_r;
  logic [1:0] count_r;
  logic       push_s;
  logic       pop_s;

  // Handshake decode and head presentation
  always_comb begin
    in_ready  = (count_r != 2'd2);
    out_valid = (count_r != 2'd0);
    push_s    = in_valid && (count_r != 2'd2);
    pop_s     = out_ready && (count_r != 2'd0);
    out_data  = mem0_r;
    count     = count_r;
  end

  // Storage: mem0_r is always the head, mem1_r the second entry
  always_ff @(posedge clk) begin
    if (reset) begin
      mem0_r  <= 2'b00;
      mem1_r  <= 2'b00;
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            mem0_r <= in_data;
          end else begin
            mem1_r <= in_data;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          mem0_r  <= mem1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            mem0_r <= in_data;
          end else begin
            mem0_r <= mem1_r;
            mem1_r <= in_data;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/ppbuf_interleave_reader.sv
// Drains a completed ping-pong bank in column-wise interleaved order and
// streams the bits out over valid/ready, covering the 1-cycle SDPR read latency.
module ppbuf_interleave_reader
  import wimax_pkg::*;
#(
  parameter int NCBPS  = NCBPS_QPSK12,
  parameter int D      = INTLV_D,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              block_ready,
  output logic [ADDR_W-1:0] rdaddress,
  output logic              rden,
  input  logic              q,
  output logic              out_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              block_done,
  output logic              overflow
);

  localparam int                NCOL    = NCBPS / D;
  localparam logic [ADDR_W-1:0] D_W     = ADDR_W'(D);
  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(NCOL - 1);
  localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(D - 1);

  rd_state_t         state_r;
  rd_state_t         state_nxt_s;
  logic [ADDR_W-1:0] col_r;
  logic [ADDR_W-1:0] row_r;
  logic              pending_r;
  logic              overflow_r;
  logic              in_flight_r;
  logic              in_flight_last_r;

  logic              fifo_valid_s;
  logic              fifo_ready_s;
  logic [1:0]        fifo_head_s;
  logic [1:0]        fifo_count_s;

  logic [2:0]        credit_use_s;
  logic              pop_s;
  logic              issue_s;
  logic              last_rd_s;
  logic              done_s;
  logic              start_s;

  // Credit is judged on post-pop occupancy so a steady 1 bit/clock fits in 2 entries
  always_comb begin
    pop_s        = fifo_valid_s && out_ready;
    credit_use_s = {1'b0, fifo_count_s} - {2'b00, pop_s} + {2'b00, in_flight_r};
    last_rd_s    = (col_r == COL_MAX) && (row_r == ROW_MAX);
    issue_s      = (state_r == READ) && (credit_use_s < 3'd2) && fifo_ready_s;
    done_s       = pop_s && fifo_head_s[1];
    case (state_r)
      IDLE:    start_s = block_ready || pending_r;
      DRAIN:   start_s = done_s && (block_ready || pending_r);
      default: start_s = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_nxt_s = READ;
        else         state_nxt_s = IDLE;
      end
      READ: begin
        if (issue_s && last_rd_s) state_nxt_s = DRAIN;
        else                      state_nxt_s = READ;
      end
      DRAIN: begin
        if (start_s)     state_nxt_s = READ;
        else if (done_s) state_nxt_s = IDLE;
        else             state_nxt_s = DRAIN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Address counters, read pipeline tracking and pending/overflow bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      col_r            <= '0;
      row_r            <= '0;
      pending_r        <= 1'b0;
      overflow_r       <= 1'b0;
      in_flight_r      <= 1'b0;
      in_flight_last_r <= 1'b0;
    end else begin
      in_flight_r      <= issue_s;
      in_flight_last_r <= issue_s && last_rd_s;

      if (start_s) begin
        col_r <= '0;
        row_r <= '0;
      end else if (issue_s) begin
        if (col_r == COL_MAX) begin
          col_r <= '0;
          row_r <= (row_r == ROW_MAX) ? '0 : row_r + ADDR_W'(1);
        end else begin
          col_r <= col_r + ADDR_W'(1);
        end
      end

      // A pulse arriving as DRAIN hands over is taken as the next block, not an error
      case (state_r)
        IDLE: pending_r <= 1'b0;
        READ, DRAIN: begin
          if (start_s) begin
            pending_r <= pending_r && block_ready;
          end else if (block_ready) begin
            if (pending_r) overflow_r <= 1'b1;
            else           pending_r  <= 1'b1;
          end
        end
        default: pending_r <= 1'b0;
      endcase
    end
  end

  skid_fifo2 u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_flight_r),
    .in_ready  (fifo_ready_s),
    .in_data   ({in_flight_last_r, q}),
    .out_valid (fifo_valid_s),
    .out_ready (out_ready),
    .out_data  (fifo_head_s),
    .count     (fifo_count_s)
  );

  // Output decode
  always_comb begin
    rden       = issue_s;
    rdaddress  = (col_r * D_W) + row_r;
    out_valid  = fifo_valid_s;
    out_bit    = fifo_head_s[0];
    out_last   = fifo_valid_s && fifo_head_s[1];
    block_done = done_s;
    overflow   = overflow_r;
  end

endmodule
